// File: rtl/pwm_bus_pkg.sv
// Shared definitions for the PWM register bus: widths, arbiter FSM encoding and master IDs.
// Used by the arbiter, the I2C bridge and the fade sequencer.
package pwm_bus_pkg;

  localparam int unsigned PWM_ADDR_W = 8;
  localparam int unsigned PWM_DATA_W = 16;

  // Starvation counter covers MAX_WAIT up to 15, read-wait counter covers RD_LAT up to 7.
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned LAT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_e;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [PWM_ADDR_W-1:0] addr;
    logic [PWM_DATA_W-1:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/pwm_arb_pick.sv
// Combinational winner selection: fixed priority to M0, M1 forced once it has waited MAX_WAIT grants.
module pwm_arb_pick
  import pwm_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                req0,
  input  logic                req1,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_c,
  output logic                winner_c
);

  always_comb begin
    grant_c  = req0 | req1;
    winner_c = M0_ID;
    if (req1 && (!req0 || (starve_cnt == STARVE_W'(MAX_WAIT)))) begin
      winner_c = M1_ID;
    end
  end

endmodule

// File: rtl/pwm_reg_arbiter.sv
// Two-master arbiter for the PWM register port: one strobe per granted transaction,
// ack and read data returned to the owner.
module pwm_reg_arbiter
  import pwm_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = PWM_ADDR_W,
  parameter int unsigned DATA_W   = PWM_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wr_en_o,
  output logic              rd_en_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [LAT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                owner_d;
  logic                wr_en_d, rd_en_d, busy_d;
  logic                m0_ack_d, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_d, m1_rdata_d;
  logic                grant_c, winner_c;

  pwm_arb_pick #(
    .MAX_WAIT(MAX_WAIT)
  ) u_pick (
    .req0      (m0_req_i),
    .req1      (m1_req_i),
    .starve_cnt(starve_q),
    .grant_c   (grant_c),
    .winner_c  (winner_c)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    rd_cnt_d   = rd_cnt_q;
    we_d       = we_q;
    addr_d     = addr_o;
    wdata_d    = wdata_o;
    owner_d    = owner_o;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_o;
    m1_rdata_d = m1_rdata_o;

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          state_d = ST_ISSUE;
          owner_d = winner_c;
          if (winner_c == M1_ID) begin
            we_d     = m1_we_i;
            addr_d   = m1_addr_i;
            wdata_d  = m1_wdata_i;
            starve_d = '0;
          end else begin
            we_d    = m0_we_i;
            addr_d  = m0_addr_i;
            wdata_d = m0_wdata_i;
            // Count M0 wins only while M1 is actually waiting.
            if (m1_req_i && (starve_q != STARVE_W'(MAX_WAIT))) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end
          wr_en_d = we_d;
          rd_en_d = ~we_d;
        end
      end

      ST_ISSUE: begin
        rd_cnt_d = '0;
        if (we_q) begin
          state_d  = ST_ACK;
          m0_ack_d = (owner_o == M0_ID);
          m1_ack_d = (owner_o == M1_ID);
        end else begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // Last wait cycle is the one where rdata_i is valid.
        if (rd_cnt_q == LAT_W'(RD_LAT - 1)) begin
          state_d  = ST_ACK;
          m0_ack_d = (owner_o == M0_ID);
          m1_ack_d = (owner_o == M1_ID);
          if (owner_o == M1_ID) begin
            m1_rdata_d = rdata_i;
          end else begin
            m0_rdata_d = rdata_i;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + LAT_W'(1);
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      rd_cnt_q   <= '0;
      we_q       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      owner_o    <= 1'b0;
      wr_en_o    <= 1'b0;
      rd_en_o    <= 1'b0;
      busy_o     <= 1'b0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_cnt_q   <= rd_cnt_d;
      we_q       <= we_d;
      addr_o     <= addr_d;
      wdata_o    <= wdata_d;
      owner_o    <= owner_d;
      wr_en_o    <= wr_en_d;
      rd_en_o    <= rd_en_d;
      busy_o     <= busy_d;
      m0_ack_o   <= m0_ack_d;
      m1_ack_o   <= m1_ack_d;
      m0_rdata_o <= m0_rdata_d;
      m1_rdata_o <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Bench for pwm_reg_arbiter: RD_LAT=1 instance with scoreboard and vector table,
// plus an RD_LAT=3 instance for read latency and mid-transaction reset.
module tb_pwm_reg_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk, rst_n;

  // RD_LAT=1 instance
  logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [AW-1:0] m0_addr, m1_addr, addr_o;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, wdata_o, rdata_i;
  logic          wr_en, rd_en, busy, owner;

  // RD_LAT=3 instance
  logic          m0_req3, m0_we3, m0_ack3, m1_req3, m1_we3, m1_ack3;
  logic [AW-1:0] m0_addr3, m1_addr3, addr3;
  logic [DW-1:0] m0_wdata3, m1_wdata3, m0_rdata3, m1_rdata3, wdata3, rdata3;
  logic          wr_en3, rd_en3, busy3, owner3;

  pwm_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_WAIT(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .addr_o(addr_o), .wdata_o(wdata_o), .wr_en_o(wr_en), .rd_en_o(rd_en),
    .rdata_i(rdata_i), .busy_o(busy), .owner_o(owner)
  );

  pwm_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_WAIT(4)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req3), .m0_we_i(m0_we3), .m0_addr_i(m0_addr3), .m0_wdata_i(m0_wdata3),
    .m0_ack_o(m0_ack3), .m0_rdata_o(m0_rdata3),
    .m1_req_i(m1_req3), .m1_we_i(m1_we3), .m1_addr_i(m1_addr3), .m1_wdata_i(m1_wdata3),
    .m1_ack_o(m1_ack3), .m1_rdata_o(m1_rdata3),
    .addr_o(addr3), .wdata_o(wdata3), .wr_en_o(wr_en3), .rd_en_o(rd_en3),
    .rdata_i(rdata3), .busy_o(busy3), .owner_o(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: valid data only in the cycle RD_LAT after the strobe, 0xDEAD otherwise.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    logic [AW-1:0] x;
    x = a ^ 8'h7A;
    return {x, x};
  endfunction

  logic       pipe1;
  logic [2:0] pipe3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1 <= 1'b0;
      pipe3 <= 3'b000;
    end else begin
      pipe1 <= rd_en;
      pipe3 <= {pipe3[1:0], rd_en3};
    end
  end
  assign rdata_i = pipe1    ? rd_model(addr_o) : 16'hDEAD;
  assign rdata3  = pipe3[2] ? rd_model(addr3)  : 16'hDEAD;

  typedef struct {
    bit            m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_cyc;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    bit            m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } sb_t;

  sb_t           strobe_q[$];
  sb_t           ack_q[$];
  int            checks;
  int            errors;
  logic [DW-1:0] exp_rd0, exp_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit m, input bit req, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end
  endtask

  // Scoreboard: strobes pop the grant-order queue, acks pop the completion queue.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_rd0 = '0;
        exp_rd1 = '0;
        strobe_q.delete();
        ack_q.delete();
      end else begin
        if (wr_en || rd_en) begin
          chk("sb_strobe_expected", 32'(strobe_q.size() > 0), 32'd1);
          if (strobe_q.size() > 0) begin
            e = strobe_q.pop_front();
            chk("sb_owner", 32'(owner), 32'(e.m));
            chk("sb_wr_en", 32'(wr_en), 32'(e.we));
            chk("sb_rd_en", 32'(rd_en), 32'(!e.we));
            chk("sb_addr", 32'(addr_o), 32'(e.addr));
            if (e.we) chk("sb_wdata", 32'(wdata_o), 32'(e.wdata));
            ack_q.push_back(e);
          end
        end
        if (m0_ack || m1_ack) begin
          chk("sb_ack_expected", 32'(ack_q.size() > 0), 32'd1);
          chk("sb_ack_single", 32'(m0_ack & m1_ack), 32'd0);
          if (ack_q.size() > 0) begin
            e = ack_q.pop_front();
            chk("sb_ack_master", 32'(m1_ack), 32'(e.m));
            if (!e.we) begin
              if (e.m) exp_rd1 = e.rdata;
              else     exp_rd0 = e.rdata;
            end
          end
        end
        chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd0));
        chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd1));
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Holds req continuously, advancing address after each ack, until n transactions complete.
  task automatic drive_m(input bit m, input int n, input logic [AW-1:0] base);
    int done, budget;
    logic [AW-1:0] a;
    done = 0; budget = 0; a = base;
    set_req(m, 1'b1, 1'b1, a, {8'hC0, a});
    while (done < n && budget < 100) begin
      @(negedge clk);
      budget++;
      if ((m ? m1_ack : m0_ack) == 1'b1) begin
        done++;
        a = AW'(base + AW'(done));
        set_req(m, done < n, 1'b1, a, {8'hC0, a});
      end
    end
    chk($sformatf("drv%0d_done", m), 32'(done), 32'(n));
  endtask

  task automatic dut3_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    @(posedge clk); #1;
    m0_req3 = 1'b1; m0_we3 = 1'b0; m0_addr3 = a;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) m0_req3 = 1'b0;
      chk($sformatf("%s_c%0d_rd", tag, c), 32'(rd_en3), 32'(c == 1));
      chk($sformatf("%s_c%0d_ack", tag, c), 32'(m0_ack3), 32'(c == 5));
      chk($sformatf("%s_c%0d_busy", tag, c), 32'(busy3), 32'(c <= 5));
      if (c >= 5) chk($sformatf("%s_c%0d_rdata", tag, c), 32'(m0_rdata3), 32'(exp));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[6];
    logic [5:0] seq_b[7];
    bit         ord[11];
    int         k0, k1;
    logic [AW-1:0] a;

    vecs[0] = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 2, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 16'h0000, 3, 16'h5A5A};
    vecs[2] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 3, 16'h8585};
    vecs[3] = '{1'b1, 1'b1, 8'h00, 16'h0001, 2, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 16'h0000, 3, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b0, 8'h81, 16'h0000, 3, 16'hFBFB};
    // {wr_en, rd_en, m0_ack, m1_ack, busy, owner} for cycles 1..7
    seq_b = '{6'b100010, 6'b001010, 6'b000000, 6'b010011, 6'b000011, 6'b000111, 6'b000001};
    ord   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    checks = 0; errors = 0; exp_rd0 = '0; exp_rd1 = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    m0_req3 = 0; m0_we3 = 0; m0_addr3 = '0; m0_wdata3 = '0;
    m1_req3 = 0; m1_we3 = 0; m1_addr3 = '0; m1_wdata3 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", 32'({wr_en, rd_en, m0_ack, m1_ack, busy, owner}), 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_wdata", 32'(wdata_o), 32'd0);
    chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single-master transactions from the vector table
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      @(posedge clk); #1;
      set_req(vecs[i].m, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      strobe_q.push_back('{vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata});
      @(negedge clk);
      for (int c = 1; c <= vecs[i].ack_cyc + 1; c++) begin
        @(negedge clk);
        if (c == 1) set_req(vecs[i].m, 1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
        chk($sformatf("v%0d_c%0d_wr", i, c), 32'(wr_en), 32'(c == 1 && vecs[i].we));
        chk($sformatf("v%0d_c%0d_rd", i, c), 32'(rd_en), 32'(c == 1 && !vecs[i].we));
        chk($sformatf("v%0d_c%0d_ack0", i, c), 32'(m0_ack), 32'(c == vecs[i].ack_cyc && !vecs[i].m));
        chk($sformatf("v%0d_c%0d_ack1", i, c), 32'(m1_ack), 32'(c == vecs[i].ack_cyc && vecs[i].m));
        chk($sformatf("v%0d_c%0d_busy", i, c), 32'(busy), 32'(c <= vecs[i].ack_cyc));
      end
      chk($sformatf("v%0d_addr_hold", i), 32'(addr_o), 32'(vecs[i].addr));
      chk($sformatf("v%0d_wdata_hold", i), 32'(wdata_o), 32'(vecs[i].wdata));
    end

    // M0 drops req during its write; M1 asserted meanwhile is served after ACK
    wait_idle();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 8'h34, 16'h1234);
    strobe_q.push_back('{1'b0, 1'b1, 8'h34, 16'h1234, 16'h0000});
    strobe_q.push_back('{1'b1, 1'b0, 8'h33, 16'h0000, 16'h4949});
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b1, 8'h34, 16'h1234);
    set_req(1'b1, 1'b1, 1'b0, 8'h33, 16'h0000);
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 6) set_req(1'b1, 1'b0, 1'b0, 8'h33, 16'h0000);
      chk($sformatf("drop_c%0d", c), 32'({wr_en, rd_en, m0_ack, m1_ack, busy, owner}), 32'(seq_b[c-1]));
    end

    // Both masters requesting continuously: M1 forced after every 4 M0 grants
    wait_idle();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 11; i++) begin
      if (ord[i]) begin a = AW'(8'h80 + k1); k1++; end
      else        begin a = AW'(8'h40 + k0); k0++; end
      strobe_q.push_back('{ord[i], 1'b1, a, {8'hC0, a}, 16'h0000});
    end
    @(posedge clk); #1;
    fork
      drive_m(1'b0, 9, 8'h40);
      drive_m(1'b1, 2, 8'h80);
    join
    wait_idle();
    chk("sb_strobe_drain", 32'(strobe_q.size()), 32'd0);
    chk("sb_ack_drain", 32'(ack_q.size()), 32'd0);

    // RD_LAT=3: normal read, read abandoned by reset in RD_WAIT, then a fresh read
    dut3_read(8'h55, 16'h2F2F, "r3_pre");
    @(posedge clk); #1;
    m0_req3 = 1'b1; m0_we3 = 1'b0; m0_addr3 = 8'h66;
    @(negedge clk);
    @(negedge clk);
    m0_req3 = 1'b0;
    chk("r3_mid_strobe", 32'(rd_en3), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("r3_mid_busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r3_rst_strobes", 32'({wr_en3, rd_en3, m0_ack3, m1_ack3}), 32'd0);
    chk("r3_rst_busy_owner", 32'({busy3, owner3}), 32'd0);
    chk("r3_rst_rdata", 32'({m0_rdata3, m1_rdata3}), 32'd0);
    chk("r3_rst_addr", 32'(addr3), 32'd0);
    chk("r3_rst_wdata", 32'(wdata3), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("r3_abandon_c%0d", c), 32'({m0_ack3, busy3}), 32'd0);
    end
    dut3_read(8'h66, 16'h1C1C, "r3_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
